// File: rtl/ssp_arb_pkg.sv
// Shared types and widths for the PL022 SSP APB arbiter.
// Used by ssp_apb_arbiter and ssp_rr_arbiter.
package ssp_arb_pkg;

    localparam int APB_ADDR_W = 10;
    localparam int APB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ssp_rr_arbiter.sv
// Combinational round-robin pick.
// The lowest set request at or above ptr wins, wrapping past NUM_REQ-1.
module ssp_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssp_apb_arbiter.sv
// Round-robin arbiter sharing the PL022 SSP APB slave port between NUM_REQ requesters.
// Optional SSP_ARB_PREADY_EN: ACCESS waits for PREADY; otherwise ACCESS is one cycle.
module ssp_apb_arbiter
    import ssp_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = APB_DATA_W,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    output logic [1:0]                fsm_state
);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  pending;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                access_done;

    logic [NUM_REQ-1:0]  ack_d;
    logic [DATA_W-1:0]   rdata_d;
    logic [IDX_W-1:0]    grant_d;
    logic                psel_d;
    logic                penable_d;
    logic                pwrite_d;
    logic [ADDR_W-1:0]   paddr_d;
    logic [DATA_W-1:0]   pwdata_d;

`ifdef SSP_ARB_PREADY_EN
    assign access_done = PREADY;
`else
    logic pready_unused;
    assign pready_unused = PREADY;
    assign access_done   = 1'b1;
`endif

    // A requester is masked in its own ack cycle so a held req is not served twice.
    assign pending   = req & ~ack;
    assign fsm_state = state_q;

    ssp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (pending),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            ack      <= '0;
            rdata    <= '0;
            grant_id <= '0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ack      <= ack_d;
            rdata    <= rdata_d;
            grant_id <= grant_d;
            PSEL     <= psel_d;
            PENABLE  <= penable_d;
            PWRITE   <= pwrite_d;
            PADDR    <= paddr_d;
            PWDATA   <= pwdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid)  state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (access_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d     = '0;
        rdata_d   = rdata;
        grant_d   = grant_id;
        psel_d    = PSEL;
        penable_d = PENABLE;
        pwrite_d  = PWRITE;
        paddr_d   = PADDR;
        pwdata_d  = PWDATA;
        ptr_d     = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = req_write[pick_idx];
                    paddr_d   = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    pwdata_d  = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    grant_d   = pick_idx;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (access_done) begin
                    if (!PWRITE) begin
                        rdata_d = PRDATA;
                    end
                    ack_d[grant_id] = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = '0;
                    pwdata_d  = '0;
                    ptr_d     = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ssp_apb_arbiter.sv
// Directed bench for ssp_apb_arbiter: vector table of single transfers plus
// hand-written reset, contention, held-req, early-drop and (optional) PREADY sequences.
module tb_ssp_apb_arbiter;
    import ssp_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int IW = 1;

    logic            PCLK;
    logic            PRESET;
    logic [N-1:0]    req;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic [IW-1:0]   grant_id;
    logic            PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA;
    logic            PREADY;
    logic [1:0]      fsm_state;

    ssp_apb_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .grant_id  (grant_id),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .fsm_state (fsm_state)
    );

    typedef struct {
        logic          is_write;
        int            id;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prdata;
        logic [DW-1:0] exp_rdata;
        logic [N-1:0]  exp_ack;
    } vec_t;

    vec_t          vecs[6];
    logic [DW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    // clock / reset
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic drive_req(input int id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[id]               = 1'b1;
        req_write[id]         = w;
        req_addr[id*AW +: AW] = a;
        req_wdata[id*DW +: DW] = d;
    endtask

    task automatic drop_req(input int id);
        req[id]               = 1'b0;
        req_write[id]         = 1'b0;
        req_addr[id*AW +: AW] = '0;
        req_wdata[id*DW +: DW] = '0;
    endtask

    // scoreboard: read data expectations are queued at issue, popped at ack
    task automatic sb_check_read(input string name);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(name, rdata, e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        drive_req(v.id, v.is_write, v.addr, v.wdata);
        if (!v.is_write) exp_q.push_back(v.exp_rdata);
        tick();
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_pwrite", PWRITE, v.is_write);
        chk("setup_paddr", PADDR, v.addr);
        chk("setup_pwdata", PWDATA, v.wdata);
        chk("setup_grant_id", grant_id, v.id);
        chk("setup_state", fsm_state, SETUP);
        PRDATA = v.prdata;
        tick();
        chk("access_psel", PSEL, 1);
        chk("access_penable", PENABLE, 1);
        chk("access_paddr", PADDR, v.addr);
        chk("access_ack", ack, 0);
        chk("access_state", fsm_state, ACCESS);
        tick();
        chk("done_ack", ack, v.exp_ack);
        chk("done_psel", PSEL, 0);
        chk("done_penable", PENABLE, 0);
        chk("done_paddr", PADDR, 0);
        chk("done_pwdata", PWDATA, 0);
        chk("done_grant_id", grant_id, v.id);
        if (!v.is_write) sb_check_read("done_rdata");
        else chk("done_rdata_hold", rdata, v.exp_rdata);
        drop_req(v.id);
        PRDATA = '0;
        tick();
        chk("idle_psel", PSEL, 0);
        chk("idle_ack", ack, 0);
    endtask

    int exp_grant[4];
    int seen;
    int waited;

    initial begin
        //            write  id  addr     wdata     prdata    exp_rdata exp_ack
        vecs[0] = '{1'b1, 0, 10'h002, 16'hA5C3, 16'hDEAD, 16'h0000, 2'b01};
        vecs[1] = '{1'b0, 1, 10'h003, 16'h0000, 16'h1234, 16'h1234, 2'b10};
        vecs[2] = '{1'b1, 1, 10'h3FF, 16'hFFFF, 16'h0BAD, 16'h1234, 2'b10};
        vecs[3] = '{1'b0, 0, 10'h000, 16'h1111, 16'h8001, 16'h8001, 2'b01};
        vecs[4] = '{1'b0, 1, 10'h155, 16'h2222, 16'h0000, 16'h0000, 2'b10};
        vecs[5] = '{1'b0, 0, 10'h2AA, 16'h3333, 16'hC3C3, 16'hC3C3, 2'b01};
        exp_grant = '{0, 1, 0, 1};

        PRESET    = 1'b1;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
`ifdef SSP_ARB_PREADY_EN
        PREADY    = 1'b1;
`else
        PREADY    = 1'b0;
`endif

        tick();
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_state", fsm_state, IDLE);
        PRESET = 1'b0;
        tick();
        chk("idle_no_req_psel", PSEL, 0);
        chk("idle_no_req_paddr", PADDR, 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // reset asserted during ACCESS clears everything at once; no ack afterwards
        drive_req(0, 1'b1, 10'h00F, 16'h7777);
        tick();
        tick();
        chk("midrst_pre_penable", PENABLE, 1);
        PRESET = 1'b1;
        #1;
        chk("midrst_psel", PSEL, 0);
        chk("midrst_penable", PENABLE, 0);
        chk("midrst_pwrite", PWRITE, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_state", fsm_state, IDLE);
        drop_req(0);
        tick();
        tick();
        PRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_ack", ack, 0);
            chk("midrst_no_psel", PSEL, 0);
        end

        // contention from a fresh pointer: grants alternate 0,1,0,1 every 3 cycles
        drive_req(0, 1'b1, 10'h010, 16'h0100);
        drive_req(1, 1'b1, 10'h011, 16'h0111);
        seen = 0;
        for (int c = 1; c <= 20 && seen < 4; c++) begin
            tick();
            if (ack != '0) begin
                chk("cont_ack", ack, (exp_grant[seen] == 0) ? 32'd1 : 32'd2);
                chk("cont_grant_id", grant_id, exp_grant[seen]);
                chk("cont_cycle", c, 3 * (seen + 1));
                seen++;
                if (seen == 4) begin
                    drop_req(0);
                    drop_req(1);
                end
            end
        end
        chk("cont_count", seen, 4);
        tick();
        chk("cont_idle_psel", PSEL, 0);

        // held req: not reissued from the ack cycle, reissued the cycle after
        drive_req(0, 1'b0, 10'h020, 16'h0000);
        PRDATA = 16'h4242;
        exp_q.push_back(16'h4242);
        tick();
        tick();
        tick();
        chk("held_ack1", ack, 2'b01);
        sb_check_read("held_rdata1");
        tick();
        chk("held_no_setup_psel", PSEL, 0);
        chk("held_no_setup_state", fsm_state, IDLE);
        tick();
        chk("held_restart_psel", PSEL, 1);
        chk("held_restart_state", fsm_state, SETUP);
        PRDATA = 16'h4343;
        exp_q.push_back(16'h4343);
        tick();
        tick();
        chk("held_ack2", ack, 2'b01);
        sb_check_read("held_rdata2");
        drop_req(0);
        PRDATA = '0;
        tick();

        // req dropped during SETUP: latched command still completes
        drive_req(1, 1'b1, 10'h030, 16'hBEEF);
        tick();
        drop_req(1);
        tick();
        chk("drop_pwdata_held", PWDATA, 16'hBEEF);
        chk("drop_paddr_held", PADDR, 10'h030);
        tick();
        chk("drop_ack", ack, 2'b10);
        tick();
        chk("drop_idle_psel", PSEL, 0);

`ifdef SSP_ARB_PREADY_EN
        // PREADY low for three ACCESS cycles stretches the transfer
        drive_req(1, 1'b0, 10'h044, 16'h0000);
        PRDATA = 16'h5A5A;
        exp_q.push_back(16'h5A5A);
        tick();
        PREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_psel", PSEL, 1);
            chk("wait_penable", PENABLE, 1);
            chk("wait_paddr", PADDR, 10'h044);
            chk("wait_ack", ack, 0);
        end
        PREADY = 1'b1;
        waited = 0;
        tick();
        waited++;
        while (ack == '0 && waited < 4) begin
            tick();
            waited++;
        end
        chk("wait_ack_latency", waited, 1);
        chk("wait_ack_val", ack, 2'b10);
        sb_check_read("wait_rdata");
        drop_req(1);
        tick();
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
